// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - rv32i control word, funct3 enums and MEM stage types
package mem_stage_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic       load_regfile;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
        logic [4:0] rd;
    } rv32i_control_word;

    typedef struct packed {
        logic            read;
        logic            write;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [3:0]      be;
    } mem_req_t;

    typedef struct packed {
        rv32i_control_word ctrl;
        logic [XLEN-1:0]   data;
        logic [XLEN-1:0]   alu;
        logic              br_en;
        logic [XLEN-1:0]   pc;
        logic [3:0]        be;
    } mem_wb_t;

endpackage

// File: rtl/mem_stage_align.sv
// rtl/mem_stage_align.sv - byte-enable and store-lane replication for data memory
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [3:0]      byte_enable_o,
    output logic [XLEN-1:0] wdata_o
);

    // Store funct3 values alias the signed loads, so one decode serves both.
    always_comb begin
        byte_enable_o = 4'b1111;
        wdata_o       = rs2_i;
        case (funct3_i)
            LB, LBU: begin
                byte_enable_o = 4'b0001 << addr_i;
                wdata_o       = {4{rs2_i[7:0]}};
            end
            LH, LHU: begin
                byte_enable_o = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o       = {2{rs2_i[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage with data-memory handshake FSM and MEM/WB register
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  rv32i_control_word ctrl_in,
    input  logic [XLEN-1:0]   alu_in,
    input  logic [XLEN-1:0]   rs2_in,
    input  logic              br_en_in,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_resp,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [XLEN-1:0]   dmem_address,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [3:0]        dmem_byte_enable,
    output logic              stall_out,
    output rv32i_control_word ctrl_out,
    output logic [XLEN-1:0]   data_out,
    output logic [XLEN-1:0]   alu_out,
    output logic              br_en_out,
    output logic [XLEN-1:0]   pc_out,
    output logic [3:0]        mem_byte_enable_out
);

    mem_state_t      state_q, state_d;
    mem_req_t        req_q, req_d;
    mem_wb_t         wb_q, wb_d, wb_load;
    logic [3:0]      align_be;
    logic [XLEN-1:0] align_wdata;
    logic            mem_op;
    logic            stall;

    assign mem_op = ctrl_in.mem_read | ctrl_in.mem_write;

    mem_align u_align (
        .funct3_i      (ctrl_in.funct3),
        .addr_i        (alu_in[1:0]),
        .rs2_i         (rs2_in),
        .byte_enable_o (align_be),
        .wdata_o       (align_wdata)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        wb_d    = '0;
        stall   = 1'b0;

        wb_load       = '0;
        wb_load.ctrl  = ctrl_in;
        wb_load.alu   = alu_in;
        wb_load.br_en = br_en_in;
        wb_load.pc    = pc_in;
        wb_load.be    = align_be;

        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    state_d     = REQ;
                    req_d.read  = ctrl_in.mem_read;
                    req_d.write = ctrl_in.mem_write & ~ctrl_in.mem_read;
                    req_d.addr  = {alu_in[XLEN-1:2], 2'b00};
                    req_d.wdata = align_wdata;
                    req_d.be    = align_be;
                    stall       = 1'b1;
                end else begin
                    wb_d = wb_load;
                end
            end
            REQ: begin
                if (dmem_resp) begin
                    state_d     = IDLE;
                    req_d.read  = 1'b0;
                    req_d.write = 1'b0;
                    wb_d        = wb_load;
                    wb_d.data   = dmem_rdata;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset must release upstream immediately even if EX/MEM still holds a memory op.
    assign stall_out = stall & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wb_q    <= wb_d;
        end
    end

    assign dmem_read           = req_q.read;
    assign dmem_write          = req_q.write;
    assign dmem_address        = req_q.addr;
    assign dmem_wdata          = req_q.wdata;
    assign dmem_byte_enable    = req_q.be;
    assign ctrl_out            = wb_q.ctrl;
    assign data_out            = wb_q.data;
    assign alu_out             = wb_q.alu;
    assign br_en_out           = wb_q.br_en;
    assign pc_out              = wb_q.pc;
    assign mem_byte_enable_out = wb_q.be;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    rv32i_control_word ctrl_in;
    logic [31:0]       alu_in, rs2_in, pc_in, dmem_rdata;
    logic              br_en_in, dmem_resp;
    logic              dmem_read, dmem_write, stall_out, br_en_out;
    logic [31:0]       dmem_address, dmem_wdata, data_out, alu_out, pc_out;
    logic [3:0]        dmem_byte_enable, mem_byte_enable_out;
    rv32i_control_word ctrl_out;

    mem_stage dut (
        .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .alu_in(alu_in), .rs2_in(rs2_in),
        .br_en_in(br_en_in), .pc_in(pc_in), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
        .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable), .stall_out(stall_out),
        .ctrl_out(ctrl_out), .data_out(data_out), .alu_out(alu_out), .br_en_out(br_en_out),
        .pc_out(pc_out), .mem_byte_enable_out(mem_byte_enable_out)
    );

    typedef struct {
        string       name;
        logic        lrf, mr, mw;
        logic [2:0]  f3;
        logic [31:0] alu, rs2, pc, rdata;
        int          wait_n, lit_stall;
        logic [3:0]  lit_be;
        logic        lit_word_en;
        logic [31:0] lit_word;
    } instr_t;

    typedef struct {
        logic              bubble;
        rv32i_control_word ctrl;
        logic [31:0]       alu, pc, data;
        logic              br;
        logic [3:0]        be;
    } wb_t;

    int          checks = 0;
    int          errors = 0;
    int          pc_next = 32'h1000;
    string       cur_name = "reset";
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_rd, exp_wr;
    logic [31:0] exp_addr, exp_wd;
    logic [3:0]  exp_be;
    wb_t         exp_wb, wb_pending, bubble_wb;
    instr_t      prog[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s/%s actual=%h required=%h", cur_name, name, act, exp);
        end
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    // Access of sz bytes occupies the lanes at addr rounded down to sz.
    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] a);
        int sz   = size_of(f3);
        int base = (sz == 4) ? 0 : (int'(a) / sz) * sz;
        return 4'(((1 << sz) - 1) << base);
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] rs2);
        int          sz   = size_of(f3);
        logic [63:0] lane = {32'b0, rs2} & ((64'd1 << (8 * sz)) - 64'd1);
        logic [63:0] w    = 64'd0;
        for (int i = 0; i < 4 / sz; i++) w = w | (lane << (8 * sz * i));
        return w[31:0];
    endfunction

    function automatic instr_t mk(input string n, input logic [1:0] kind, input logic lrf,
                                  input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rs2,
                                  input int w, input logic [31:0] rdata, input int ls,
                                  input logic [3:0] lbe, input logic lwen, input logic [31:0] lword);
        instr_t t;
        t.name = n; t.mr = kind[0]; t.mw = kind[1]; t.lrf = lrf; t.f3 = f3;
        t.alu = alu; t.rs2 = rs2; t.wait_n = w; t.rdata = rdata; t.lit_stall = ls;
        t.lit_be = lbe; t.lit_word_en = lwen; t.lit_word = lword;
        t.pc = pc_next;
        pc_next = pc_next + 4;
        return t;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_out", 32'(stall_out), 32'(exp_stall));
            chk("dmem_read", 32'(dmem_read), 32'(exp_rd));
            chk("dmem_write", 32'(dmem_write), 32'(exp_wr));
            if (exp_rd || exp_wr) begin
                chk("dmem_address", dmem_address, exp_addr);
                chk("dmem_byte_enable", 32'(dmem_byte_enable), 32'(exp_be));
                if (exp_wr) chk("dmem_wdata", dmem_wdata, exp_wd);
            end
            if (exp_wb.bubble) begin
                chk("bubble_ctrl", {29'b0, ctrl_out.load_regfile, ctrl_out.mem_read, ctrl_out.mem_write}, 32'd0);
            end else begin
                chk("ctrl_out", 32'(ctrl_out), 32'(exp_wb.ctrl));
                chk("alu_out", alu_out, exp_wb.alu);
                chk("pc_out", pc_out, exp_wb.pc);
                chk("br_en_out", 32'(br_en_out), 32'(exp_wb.br));
                chk("mem_byte_enable_out", 32'(mem_byte_enable_out), 32'(exp_wb.be));
                if (exp_wb.ctrl.mem_read) chk("data_out", data_out, exp_wb.data);
            end
        end
    end

    task automatic run_instr(input instr_t t);
        logic memop  = t.mr | t.mw;
        int   last   = memop ? t.wait_n + 1 : 0;
        int   stalls = 0;
        wb_t  full;
        cur_name = t.name;
        ctrl_in.load_regfile = t.lrf;
        ctrl_in.mem_read     = t.mr;
        ctrl_in.mem_write    = t.mw;
        ctrl_in.funct3       = t.f3;
        ctrl_in.rd           = t.pc[6:2];
        alu_in   = t.alu;
        rs2_in   = t.rs2;
        pc_in    = t.pc;
        br_en_in = t.alu[0];
        full.bubble = 1'b0;
        full.ctrl   = ctrl_in;
        full.alu    = t.alu;
        full.pc     = t.pc;
        full.data   = t.rdata;
        full.br     = t.alu[0];
        full.be     = model_be(t.f3, t.alu[1:0]);
        for (int c = 0; c <= last; c++) begin
            dmem_resp  = memop && (c == last);
            dmem_rdata = dmem_resp ? t.rdata : $urandom();
            exp_stall  = memop && (c < last);
            exp_rd     = memop && (c > 0) && t.mr;
            exp_wr     = memop && (c > 0) && t.mw && !t.mr;
            exp_addr   = t.alu & ~32'h3;
            exp_be     = full.be;
            exp_wd     = model_wd(t.f3, t.rs2);
            wb_pending = (memop && (c < last)) ? bubble_wb : full;
            @(negedge clk);
            if (stall_out) stalls++;
            if (memop && c > 0) begin
                chk("lit_be", 32'(dmem_byte_enable), 32'(t.lit_be));
                if (t.mw && t.lit_word_en) chk("lit_wdata", dmem_wdata, t.lit_word);
            end
            @(posedge clk);
            #1;
            exp_wb = wb_pending;
        end
        dmem_resp = 1'b0;
        chk("stall_cycles", 32'(stalls), 32'(t.lit_stall));
        if (t.mr && t.lit_word_en) chk("lit_data_out", data_out, t.lit_word);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bubble_wb = '{bubble: 1'b1, ctrl: '0, alu: 32'd0, pc: 32'd0, data: 32'd0, br: 1'b0, be: 4'd0};
        exp_wb = bubble_wb;
        rst = 1'b0;
        ctrl_in = '0;
        ctrl_in.mem_read = 1'b1;
        alu_in = 32'h0; rs2_in = 32'h0; pc_in = 32'h0; br_en_in = 1'b0;
        dmem_rdata = 32'h0; dmem_resp = 1'b0;
        exp_stall = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0;
        exp_addr = 32'h0; exp_wd = 32'h0; exp_be = 4'h0;

        #1;
        chk("rst_dmem_read", 32'(dmem_read), 32'd0);
        chk("rst_dmem_write", 32'(dmem_write), 32'd0);
        chk("rst_dmem_address", dmem_address, 32'd0);
        chk("rst_stall_out", 32'(stall_out), 32'd0);
        chk("rst_ctrl_out", 32'(ctrl_out), 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_alu_out", alu_out, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_br_en_out", 32'(br_en_out), 32'd0);
        chk("rst_be_out", 32'(mem_byte_enable_out), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk_en = 1'b1;

        //            name        kind lrf f3      alu           rs2           w  rdata         stl be       wen  word
        prog.push_back(mk("alu_add", 2'b00, 1, 3'b000, 32'h0000_1234, 32'h0,        0, 32'h0,         0, 4'b0000, 0, 32'h0));
        prog.push_back(mk("lw_wait3", 2'b01, 1, 3'b010, 32'h0000_0100, 32'h0,        3, 32'hDEAD_BEEF, 4, 4'b1111, 1, 32'hDEAD_BEEF));
        prog.push_back(mk("sb_103",  2'b10, 0, 3'b000, 32'h0000_0103, 32'h0000_00AB, 1, 32'h0,         2, 4'b1000, 1, 32'hABAB_ABAB));
        prog.push_back(mk("sh_202",  2'b10, 0, 3'b001, 32'h0000_0202, 32'h0000_CAFE, 0, 32'h0,         1, 4'b1100, 1, 32'hCAFE_CAFE));
        prog.push_back(mk("sh_201",  2'b10, 0, 3'b001, 32'h0000_0201, 32'h0000_CAFE, 0, 32'h0,         1, 4'b0011, 1, 32'hCAFE_CAFE));
        prog.push_back(mk("lw_b2b",  2'b01, 1, 3'b010, 32'h0000_0300, 32'h0,        0, 32'h1122_3344, 1, 4'b1111, 1, 32'h1122_3344));
        prog.push_back(mk("sw_b2b",  2'b10, 0, 3'b010, 32'h0000_0307, 32'h5566_7788, 0, 32'h0,         1, 4'b1111, 1, 32'h5566_7788));
        prog.push_back(mk("lb_002",  2'b01, 1, 3'b000, 32'h0000_0002, 32'h0,        2, 32'hA5C3_5A3C, 3, 4'b0100, 0, 32'h0));
        prog.push_back(mk("rd_wr",   2'b11, 1, 3'b010, 32'h0000_0400, 32'hFFFF_FFFF, 0, 32'h0BAD_F00D, 1, 4'b1111, 0, 32'h0));
        prog.push_back(mk("lhu_006", 2'b01, 1, 3'b101, 32'h0000_0006, 32'h0,        1, 32'h8765_4321, 2, 4'b1100, 0, 32'h0));
        prog.push_back(mk("alu_and", 2'b00, 1, 3'b111, 32'h0000_0005, 32'h0,        0, 32'h0,         0, 4'b0000, 0, 32'h0));
        prog.push_back(mk("nop",     2'b00, 0, 3'b000, 32'h0,         32'h0,        0, 32'h0,         0, 4'b0000, 0, 32'h0));
        foreach (prog[i]) run_instr(prog[i]);

        chk_en = 1'b0;
        cur_name = "reset_mid_req";
        ctrl_in = '0;
        ctrl_in.mem_read = 1'b1;
        ctrl_in.load_regfile = 1'b1;
        ctrl_in.funct3 = 3'b010;
        alu_in = 32'h0000_0500;
        pc_in = 32'h0000_2000;
        dmem_resp = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("req_before_reset", 32'(dmem_read), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("dmem_read_in_reset", 32'(dmem_read), 32'd0);
        chk("dmem_write_in_reset", 32'(dmem_write), 32'd0);
        chk("ctrl_out_in_reset", 32'(ctrl_out), 32'd0);
        chk("stall_out_in_reset", 32'(stall_out), 32'd0);
        chk("alu_out_in_reset", alu_out, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        ctrl_in = '0;
        alu_in = 32'h0; rs2_in = 32'h0; pc_in = 32'h0; br_en_in = 1'b0;
        dmem_resp = 1'b1;
        dmem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("late_resp_dmem_read", 32'(dmem_read), 32'd0);
        chk("late_resp_stall", 32'(stall_out), 32'd0);
        @(posedge clk);
        #1;
        dmem_resp = 1'b0;
        chk("late_resp_ctrl_out", 32'(ctrl_out), 32'd0);
        chk("late_resp_no_req", 32'(dmem_read | dmem_write), 32'd0);
        exp_wb = bubble_wb;
        chk_en = 1'b1;
        run_instr(mk("alu_after_rst", 2'b00, 1, 3'b000, 32'h0000_1234, 32'h0, 0, 32'h0, 0, 4'b0000, 0, 32'h0));
        run_instr(mk("nop_end",       2'b00, 0, 3'b000, 32'h0,         32'h0, 0, 32'h0, 0, 4'b0000, 0, 32'h0));
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
